// File: rtl/sd_pkg.sv
// Shared SD definitions.
//   SD_CRC7_POLY : low-order terms of the CRC7 generator x^7 + x^3 + 1
//   SD_CNT_MAX   : default terminal count (40 counts, 0..39)
//   sd_crc7_step : one serial-bit update of a CRC7 register
package sd_pkg;

  localparam logic [6:0]  SD_CRC7_POLY = 7'h09;
  localparam int unsigned SD_CNT_MAX   = 32'h27;

  // The bit shifted out of crc[6] XORed with the incoming bit is the feedback;
  // it is folded back in at the x^3 and x^0 taps.
  function automatic logic [6:0] sd_crc7_step(input logic [6:0] crc_cur,
                                              input logic       bit_in);
    logic fb;
    fb = bit_in ^ crc_cur[6];
    return {crc_cur[5:0], 1'b0} ^ (fb ? SD_CRC7_POLY : 7'h00);
  endfunction

endpackage

// File: rtl/sd_crc_7.sv
// Serial SD CRC7 engine, MSB first.
// Ports:
//   clk     : clock, rising edge
//   reset_n : asynchronous active-low reset, clears crc
//   init    : synchronous clear, has priority over absorption
//   enable  : absorb bitval this cycle
//   bitval  : serial data bit
//   crc     : current CRC7 remainder
module sd_crc_7
  import sd_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init,
  input  logic       enable,
  input  logic       bitval,
  output logic [6:0] crc
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      crc <= 7'h00;
    end else if (init) begin
      crc <= 7'h00;
    end else if (enable) begin
      crc <= sd_crc7_step(crc, bitval);
    end
  end

endmodule

// File: rtl/counter_seq.sv
// Sequence counter with running SD CRC7.
// A start_strb pulse begins a sequence of MAX+1 enabled counts; every enabled
// count absorbs bitval into the CRC. strb marks the last enabled count, after
// which the block goes idle and the CRC holds its final value.
// Ports:
//   clk        : clock, rising edge
//   reset_n    : asynchronous active-low reset
//   enable     : count/shift qualifier
//   start_strb : start (or restart) a sequence, clears CRC
//   bitval     : serial data bit, MSB first
//   cntr       : current count
//   strb       : terminal-count pulse (combinational)
//   busy       : sequence in progress
//   crc        : running CRC7
module counter_seq
  import sd_pkg::*;
#(
  parameter int unsigned DW  = 8,
  parameter int unsigned MAX = SD_CNT_MAX
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          enable,
  input  logic          start_strb,
  input  logic          bitval,
  output logic [DW-1:0] cntr,
  output logic          strb,
  output logic          busy,
  output logic [6:0]    crc
);

  localparam logic [DW-1:0] MAX_C = DW'(MAX);

  logic running;
  logic step;

  assign step = running & enable;
  assign strb = step & (cntr == MAX_C);
  assign busy = running;

  // start_strb outranks the terminal count, so a start coinciding with strb
  // restarts instead of ending the sequence.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      running <= 1'b0;
      cntr    <= '0;
    end else if (start_strb) begin
      running <= 1'b1;
      cntr    <= '0;
    end else if (strb) begin
      running <= 1'b0;
      cntr    <= '0;
    end else if (step) begin
      cntr    <= cntr + DW'(1);
    end
  end

  sd_crc_7 u_crc (
    .clk     (clk),
    .reset_n (reset_n),
    .init    (start_strb),
    .enable  (step),
    .bitval  (bitval),
    .crc     (crc)
  );

endmodule

// File: tb/tb_counter_seq.sv
module tb_counter_seq;

  localparam int DW  = 8;
  localparam int MAX = 39;

  logic          clk;
  logic          reset_n;
  logic          enable;
  logic          start_strb;
  logic          bitval;
  logic [DW-1:0] cntr;
  logic          strb;
  logic          busy;
  logic [6:0]    crc;

  counter_seq #(.DW(DW), .MAX(MAX)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (enable),
    .start_strb (start_strb),
    .bitval     (bitval),
    .cntr       (cntr),
    .strb       (strb),
    .busy       (busy),
    .crc        (crc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: the sequence is the list of bits absorbed since start,
  // its CRC is the polynomial remainder of message * x^7 mod (x^7+x^3+1).
  bit          m_run;
  int          m_n;
  logic [63:0] m_msg;
  logic [6:0]  sb_q[$];
  bit          done = 0;

  function automatic logic [6:0] crc7_ref(input logic [63:0] msg, input int n);
    logic [127:0] r;
    logic [127:0] g;
    r = {64'd0, msg} << 7;
    for (int i = n + 6; i >= 7; i--) begin
      if (r[i]) begin
        g = 128'h89;
        r = r ^ (g << (i - 7));
      end
    end
    return r[6:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_run = 0;
    m_n   = 0;
    m_msg = '0;
  endtask

  // Called at a falling edge; drives inputs, checks strb, advances one cycle,
  // then checks registered outputs at the next falling edge.
  task automatic step(input logic st, input logic en, input logic b);
    start_strb = st;
    enable     = en;
    bitval     = b;
    #1;
    chk("strb", {31'd0, strb}, {31'd0, (m_run && en && m_n == MAX)});
    @(posedge clk);
    if (st) begin
      m_run = 1;
      m_n   = 0;
      m_msg = '0;
    end else if (m_run && en) begin
      m_msg = {m_msg[62:0], b};
      m_n++;
      if (m_n == MAX + 1) begin
        m_run = 0;
        sb_q.push_back(crc7_ref(m_msg, m_n));
      end
    end
    @(negedge clk);
    chk("cntr", {24'd0, cntr}, m_run ? 32'(m_n) : 32'd0);
    chk("busy", {31'd0, busy}, {31'd0, m_run});
    chk("crc",  {25'd0, crc},  {25'd0, crc7_ref(m_msg, m_n)});
  endtask

  task automatic feed40(input logic [39:0] v);
    for (int i = 39; i >= 0; i--) step(1'b0, 1'b1, v[i]);
  endtask

  // Monitor: on every terminal pulse not overridden by a start, the CRC seen
  // one cycle later must match the oldest expectation in the scoreboard.
  initial begin
    bit pend = 0;
    logic [6:0] e;
    forever begin
      @(negedge clk);
      if (pend) begin
        pend = 0;
        if (sb_q.size() == 0) begin
          chk("sb_unexpected_strb", 32'd1, 32'd0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_final_crc", {25'd0, crc}, {25'd0, e});
        end
      end
      #3;
      if (reset_n && strb && !start_strb) pend = 1;
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [39:0] r1;
    reset_n    = 1'b0;
    enable     = 1'b0;
    start_strb = 1'b0;
    bitval     = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    chk("rst_cntr", {24'd0, cntr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_crc",  {25'd0, crc},  32'd0);
    chk("rst_strb", {31'd0, strb}, 32'd0);
    reset_n = 1'b1;

    // Idle: nothing moves without start.
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1);

    // CMD0 content: known CRC7 0x4A.
    step(1'b1, 1'b1, 1'b0);
    feed40(40'h40_0000_0000);
    chk("cmd0_crc_const", {25'd0, crc}, 32'h4A);
    step(1'b0, 1'b1, 1'b1);
    chk("cmd0_crc_hold", {25'd0, crc}, 32'h4A);

    // All zeros.
    step(1'b1, 1'b1, 1'b0);
    feed40(40'h00_0000_0000);
    chk("zeros_crc_const", {25'd0, crc}, 32'h00);

    // R1 response bits 47..8 with a 5-cycle enable gap mid-sequence.
    r1 = 40'h11_0000_0900;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 39; i >= 0; i--) begin
      if (i == 24) for (int k = 0; k < 5; k++) step(1'b0, 1'b0, 1'($urandom));
      step(1'b0, 1'b1, r1[i]);
    end
    chk("r1_crc_model", {25'd0, crc}, {25'd0, crc7_ref({24'd0, r1}, 40)});

    // Restart at cntr=20.
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 20; i++) step(1'b0, 1'b1, 1'($urandom));
    chk("pre_restart_cntr", {24'd0, cntr}, 32'd20);
    step(1'b1, 1'b1, 1'b1);
    chk("restart_crc", {25'd0, crc}, 32'd0);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'($urandom));

    // Start coinciding with the terminal count.
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 39; i++) step(1'b0, 1'b1, 1'($urandom));
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'($urandom));

    // Asynchronous reset at cntr=10.
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 1'($urandom));
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("arst_cntr", {24'd0, cntr}, 32'd0);
    chk("arst_busy", {31'd0, busy}, 32'd0);
    chk("arst_crc",  {25'd0, crc},  32'd0);
    chk("arst_strb", {31'd0, strb}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    for (int i = 0; i < 50; i++) step(1'b0, 1'b1, 1'($urandom));

    // Randomised traffic.
    for (int i = 0; i < 1500; i++)
      step(1'($urandom_range(0, 79) == 0), 1'($urandom_range(0, 3) != 0), 1'($urandom));

    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_seq.md
COUNTER_SEQ -- requirements
Module: counter_seq

Interface
REQ-001 The block SHALL have parameter DW, default 8: counter width in bits.
REQ-002 The block SHALL have parameter MAX, default 8'h27: terminal count; a sequence spans MAX+1 counts, 0..MAX, so the default gives 40 counts.
REQ-003 The block SHALL have input clk, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have input reset_n, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have input enable, 1 bit: count/shift qualifier.
REQ-006 The block SHALL have input start_strb, 1 bit: one-cycle request to start a sequence and initialise the CRC.
REQ-007 The block SHALL have input bitval, 1 bit: serial data bit, MSB first, absorbed into the CRC on each counting cycle.
REQ-008 The block SHALL have output cntr, DW bits: current count.
REQ-009 The block SHALL have output strb, 1 bit: terminal-count pulse.
REQ-010 The block SHALL have output busy, 1 bit: sequence in progress.
REQ-011 The block SHALL have output crc, 7 bits: running SD CRC7.

Function
REQ-012 The block SHALL keep internal state running (reported on busy), cntr and crc.
REQ-013 When start_strb is sampled high at edge E, the block SHALL set running=1, cntr=0 and crc=7'h00 after E, whatever its prior state; a start during a sequence restarts it from 0.
REQ-014 While running=1 and enable=1, each edge SHALL increment cntr by 1 (modulo 2^DW) and SHALL absorb bitval into crc.
REQ-015 While running=1 and enable=0, the block SHALL hold cntr and crc.
REQ-016 strb SHALL be combinational and equal running & enable & (cntr==MAX); it is high for exactly one enabled cycle per sequence.
REQ-017 On the edge where strb=1, the block SHALL clear running and reset cntr to 0; crc SHALL then hold its final value until the next start_strb.
REQ-018 In total, MAX+1 enabled bits SHALL be absorbed per sequence; the final crc is valid in the cycle after strb.
REQ-019 When start_strb coincides with strb, start SHALL win: running stays 1, cntr=0, crc=0, and that cycle's bit is not absorbed.
REQ-020 When MAX=0, strb SHALL assert in the first enabled cycle after start.
REQ-021 The CRC SHALL use polynomial x^7+x^3+1; with fb = bitval XOR crc[6], the next crc is {crc[5], crc[4], crc[3], crc[2]^fb, crc[1], crc[0], fb}.
REQ-022 The crc initialisation on start_strb SHALL be synchronous and SHALL take priority over absorption.
REQ-023 When idle (running=0), the block SHALL not change cntr or crc except on start_strb.

Reset
REQ-024 While reset_n=0, the block SHALL asynchronously force running=0, cntr=0 and crc=7'h00; strb and busy are therefore 0.
REQ-025 Reset asserted mid-sequence SHALL abort the sequence; after release the block SHALL stay idle until the next start_strb.

Structure
REQ-026 The CRC7 polynomial constant and the default MAX SHALL be placed in the shared SD package.
REQ-027 The CRC7 engine SHALL be a separate sub-module, sd_crc_7, with ports: bit value, enable, clock, reset, synchronous init and 7-bit CRC.
REQ-028 counter_seq SHALL instantiate sd_crc_7 with enable = running & enable and synchronous init = start_strb.

Verification
REQ-029 Default parameters, enable=1, start pulse at edge E: cntr counts 0..39 over 40 cycles; strb high only when cntr=39; busy low afterwards.
REQ-030 Feed the 40 MSBs of an R1 response, bits 47..8, with value 48'h11_00000900_xx: final crc equals the response's transmitted CRC field [7:1].
REQ-031 Feed 40 zero bits: crc=7'h00. Feed CMD0 content 40'h40_00000000: crc=7'h4A.
REQ-032 Drop enable for 5 cycles mid-sequence: cntr and crc hold; strb arrives 5 cycles later than in REQ-029; crc matches REQ-030.
REQ-033 Assert start_strb again at cntr=20: cntr returns to 0, crc returns to 0, and strb arrives 40 enabled cycles after the restart.
REQ-034 Assert reset_n=0 asynchronously at cntr=10: outputs zero immediately; no strb after release without a new start.
